apb4_mst_bridge: RTL and testbench
==================================

Name: apb4_mst_bridge

Overview:
- Single-outstanding APB4 initiator (requester side of the APB4 bus); converts a valid/ready request/response interface into APB4 SETUP/ACCESS transfers.
- Drives peripheral slaves such as the clock/reset control unit from a local controller (boot sequencer, debug port, DMA config engine).
- One transfer in flight at a time; the response is buffered until the consumer accepts it.

Parameters:
- ADDR_WIDTH, 32, width of req_addr_i / paddr_o.
- DATA_WIDTH, 32, width of data buses; must be 8, 16 or 32.
- TIMEOUT_CYCLES, 255, ACCESS-phase cycles without pready before abort (used only with the optional feature); range 1..2^16-1.

Ports:
- clk_i  in  1  bus clock (pclk domain)
- rst_i  in  1  asynchronous reset, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_addr_i  in  ADDR_WIDTH  byte address
- req_write_i  in  1  1=write, 0=read
- req_wdata_i  in  DATA_WIDTH  write data
- req_strb_i  in  DATA_WIDTH/8  write byte strobes
- req_prot_i  in  3  APB4 protection attributes
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted when valid&ready
- rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and for aborted transfers
- rsp_err_o  out  1  pslverr captured, or timeout
- rsp_tout_o  out  1  transfer aborted by timeout
- paddr_o  out  ADDR_WIDTH  APB4 address
- pprot_o  out  3  APB4 pprot
- psel_o  out  1  APB4 select
- penable_o  out  1  APB4 enable
- pwrite_o  out  1  APB4 direction
- pwdata_o  out  DATA_WIDTH  APB4 write data
- pstrb_o  out  DATA_WIDTH/8  APB4 strobes
- prdata_i  in  DATA_WIDTH  APB4 read data
- pready_i  in  1  APB4 ready
- pslverr_i  in  1  APB4 slave error

Behaviour:
- Reset (rst_i high, takes effect immediately, asynchronous): state IDLE; every output 0, except req_ready_o=1 once in IDLE. Outputs are registered, so the reset values appear at once.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready_o=1, psel_o=0, penable_o=0.
  - On req_valid_i: latch addr/write/wdata/strb/prot and go to SETUP.
- SETUP (one cycle):
  - psel_o=1, penable_o=0.
  - paddr/pwrite/pprot/pwdata/pstrb are driven from the latched request.
  - pstrb_o is forced to 0 for reads.
  - Unconditionally go to ACCESS.
- ACCESS:
  - psel_o=1, penable_o=1; all address/control/data held stable.
  - On pready_i=1: capture rsp_rdata (prdata_i for reads, 0 for writes) and rsp_err=pslverr_i, then go to RESP.
  - pslverr_i is ignored while pready_i=0.
- RESP:
  - psel_o=0, penable_o=0, rsp_valid_o=1.
  - rsp_* held stable until rsp_ready_i; then go to IDLE and clear rsp_valid_o.
  - req_ready_o=0 in SETUP, ACCESS and RESP. No new request is accepted until the response is consumed.
- Latency: request handshake at edge N gives psel at N+1 and penable at N+2. With pready_i=1 at N+2, rsp_valid_o rises at N+3. Minimum 4 cycles per transfer with rsp_ready_i tied 1.
- Wait states: each cycle pready_i=0 in ACCESS adds one cycle; unbounded without the optional feature.
- paddr/pwrite/pprot/pwdata/pstrb hold their last values in IDLE/RESP; psel_o is the sole qualifier.
- Simultaneous events:
  - req_valid_i while in RESP is ignored (not accepted).
  - rsp_ready_i with rsp_valid_o=0 has no effect.
- Reset mid-transfer: psel/penable drop asynchronously; no response is produced for the aborted transfer.

Optional Feature:
- Macro APB4_MST_BRIDGE_TIMEOUT_EN.
- Defined:
  - A TIMEOUT-width counter clears on entry to ACCESS and increments each ACCESS cycle with pready_i=0.
  - When the count reaches TIMEOUT_CYCLES while pready_i is still 0: go to RESP with rsp_err_o=1, rsp_tout_o=1, rsp_rdata_o=0, and deassert psel/penable.
  - If pready_i=1 in the same cycle the count reaches TIMEOUT_CYCLES, pready wins (normal completion, rsp_tout_o=0).
- Undefined: no counter; ACCESS waits indefinitely; rsp_tout_o tied 0.

Test Plan:
- Write 0xDEADBEEF, strb 0xF, addr 0x0000_0004, pready=1 -> psel at N+1, penable at N+2, pwdata=0xDEADBEEF; rsp_valid at N+3 with err=0, rdata=0.
- Read addr 0x8, slave inserts 3 wait states then prdata=0x0000_0005 -> penable high for 4 cycles, pstrb_o=0, rsp_rdata_o=0x5, rsp_valid at N+6.
- Read with pready=1, pslverr=1 -> rsp_err_o=1; rsp_rdata_o=prdata value; pslverr during wait cycles is ignored.
- Two back-to-back requests with rsp_ready_i low for 5 cycles -> req_ready_o=0 throughout; second SETUP only follows the cycle after the first response handshake; rsp fields stable while stalled.
- With APB4_MST_BRIDGE_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready stuck 0 -> exactly 4 ACCESS cycles, then rsp_err_o=1, rsp_tout_o=1, rdata=0, psel=0.
- Assert rst_i during ACCESS (asynchronous to clk_i) -> psel/penable/rsp_valid go 0 immediately; req_ready_o=1 on the first edge after release; no spurious response.

Source files
------------

// File: rtl/apb4_mst_bridge.sv
// -----------------------------------------------------------------------------
// apb4_mst_bridge
//
// Single-outstanding APB4 initiator. A valid/ready request is turned into one
// APB4 SETUP + ACCESS transfer. The completion (read data, slave error) is
// held in a response register until the consumer takes it. Only one transfer
// is in flight at a time.
//
// Optional build macro:
//   APB4_MST_BRIDGE_TIMEOUT_EN - abort an ACCESS phase after TIMEOUT_CYCLES
//                                cycles without pready_i; the response then
//                                reports rsp_err_o=1, rsp_tout_o=1, rdata=0.
//                                Without it, ACCESS waits indefinitely and
//                                rsp_tout_o is tied 0.
//
// Ports:
//   clk_i, rst_i          bus clock, asynchronous active-high reset
//   req_valid_i/ready_o   request handshake
//   req_addr_i, req_write_i, req_wdata_i, req_strb_i, req_prot_i
//                         request payload (byte address, direction, data,
//                         byte strobes, APB4 protection)
//   rsp_valid_o/ready_i   response handshake
//   rsp_rdata_o           read data (0 for writes and aborted transfers)
//   rsp_err_o             pslverr captured, or timeout
//   rsp_tout_o            transfer aborted by timeout
//   paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
//                         APB4 requester outputs (all registered)
//   prdata_i, pready_i, pslverr_i
//                         APB4 completer responses
// -----------------------------------------------------------------------------
module apb4_mst_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [ADDR_WIDTH-1:0]     req_addr_i,
  input  logic                      req_write_i,
  input  logic [DATA_WIDTH-1:0]     req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   req_strb_i,
  input  logic [2:0]                req_prot_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_tout_o,
  output logic [ADDR_WIDTH-1:0]     paddr_o,
  output logic [2:0]                pprot_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [DATA_WIDTH-1:0]     pwdata_o,
  output logic [DATA_WIDTH/8-1:0]   pstrb_o,
  input  logic [DATA_WIDTH-1:0]     prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  // Elaboration-time parameter checks.
  if (DATA_WIDTH != 8 && DATA_WIDTH != 16 && DATA_WIDTH != 32) begin : g_bad_dw
    $error("apb4_mst_bridge: DATA_WIDTH must be 8, 16 or 32");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_tout
    $error("apb4_mst_bridge: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e                  state_q,     state_d;
  logic                    req_ready_q, req_ready_d;
  logic                    psel_q,      psel_d;
  logic                    penable_q,   penable_d;
  logic [ADDR_WIDTH-1:0]   paddr_q,     paddr_d;
  logic                    pwrite_q,    pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q,    pwdata_d;
  logic [STRB_W-1:0]       pstrb_q,     pstrb_d;
  logic [2:0]              pprot_q,     pprot_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q,   rsp_err_d;

`ifdef APB4_MST_BRIDGE_TIMEOUT_EN
  // Value of the wait counter during the last permitted ACCESS cycle: if
  // pready_i is still low then, the transfer is aborted at the next edge.
  localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic                    rsp_tout_q,  rsp_tout_d;
  logic [15:0]             tout_cnt_q,  tout_cnt_d;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned here gets a hold-value default first, so no
    // path through the case statement can leave one unassigned (no latches).
    state_d     = state_q;
    req_ready_d = req_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB4_MST_BRIDGE_TIMEOUT_EN
    rsp_tout_d  = rsp_tout_q;
    tout_cnt_d  = tout_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          // The latched request drives the APB bus directly; the payload
          // registers keep their value after the transfer, psel_o alone
          // qualifies them.
          paddr_d     = req_addr_i;
          pwrite_d    = req_write_i;
          pwdata_d    = req_wdata_i;
          pstrb_d     = req_write_i ? req_strb_i : '0;
          pprot_d     = req_prot_i;
          psel_d      = 1'b1;
          req_ready_d = 1'b0;
          state_d     = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
`ifdef APB4_MST_BRIDGE_TIMEOUT_EN
        tout_cnt_d = '0;
`endif
      end

      ST_ACCESS: begin
        if (pready_i) begin
          // pslverr_i is only meaningful alongside pready_i.
          rsp_rdata_d = pwrite_q ? '0 : prdata_i;
          rsp_err_d   = pslverr_i;
          rsp_valid_d = 1'b1;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          state_d     = ST_RESP;
`ifdef APB4_MST_BRIDGE_TIMEOUT_EN
          rsp_tout_d  = 1'b0;
`endif
        end else begin
`ifdef APB4_MST_BRIDGE_TIMEOUT_EN
          if (tout_cnt_q == TOUT_LAST) begin
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
            rsp_tout_d  = 1'b1;
            rsp_valid_d = 1'b1;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            state_d     = ST_RESP;
          end else begin
            tout_cnt_d = tout_cnt_q + 16'd1;
          end
`endif
        end
      end

      ST_RESP: begin
        // New requests are not looked at until the response is consumed.
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
        psel_d      = 1'b0;
        penable_d   = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: payload registers are reset along with control so that every output
  // is a defined 0 while rst_i is high, not only the handshake/select bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments only, so all
      // registers update together from pre-edge values.
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

`ifdef APB4_MST_BRIDGE_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_tout_q <= 1'b0;
      tout_cnt_q <= '0;
    end else begin
      rsp_tout_q <= rsp_tout_d;
      tout_cnt_q <= tout_cnt_d;
    end
  end

  assign rsp_tout_o = rsp_tout_q;
`else
  assign rsp_tout_o = 1'b0;
`endif

  assign req_ready_o = req_ready_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign paddr_o     = paddr_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;
  assign pprot_o     = pprot_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_apb4_mst_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb4_mst_bridge
//
// Directed bench for apb4_mst_bridge (32-bit address/data, TIMEOUT_CYCLES=4).
// Expected responses are queued when a request is issued and compared when
// the bridge presents its response. Inputs are driven and outputs sampled
// 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_apb4_mst_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = '0;
  logic        req_write_i = 1'b0;
  logic [31:0] req_wdata_i = '0;
  logic [3:0]  req_strb_i = '0;
  logic [2:0]  req_prot_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_tout_o;
  logic [31:0] paddr_o;
  logic [2:0]  pprot_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [31:0] prdata_i = '0;
  logic        pready_i = 1'b0;
  logic        pslverr_i = 1'b0;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tout;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  apb4_mst_bridge #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_write_i (req_write_i),
    .req_wdata_i (req_wdata_i),
    .req_strb_i  (req_strb_i),
    .req_prot_i  (req_prot_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .rsp_tout_o  (rsp_tout_o),
    .paddr_o     (paddr_o),
    .pprot_o     (pprot_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .pwrite_o    (pwrite_o),
    .pwdata_o    (pwdata_o),
    .pstrb_o     (pstrb_o),
    .prdata_i    (prdata_i),
    .pready_i    (pready_i),
    .pslverr_i   (pslverr_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE and check the SETUP phase it produces.
  task automatic send(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input logic [3:0] st, input logic [2:0] pr,
                      input logic [31:0] e_rdata, input logic e_err, input logic e_tout,
                      input bit push);
    exp_t e;
    check("send.req_ready", 64'(req_ready_o), 64'(1));
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    req_write_i = wr;
    req_wdata_i = wd;
    req_strb_i  = st;
    req_prot_i  = pr;
    if (push) begin
      e.rdata = e_rdata;
      e.err   = e_err;
      e.tout  = e_tout;
      exp_q.push_back(e);
    end
    step();
    req_valid_i = 1'b0;
    check("setup.psel",    64'(psel_o),    64'(1));
    check("setup.penable", 64'(penable_o), 64'(0));
    check("setup.req_rdy", 64'(req_ready_o), 64'(0));
    check("setup.paddr",   64'(paddr_o),   64'(addr));
    check("setup.pwrite",  64'(pwrite_o),  64'(wr));
    check("setup.pprot",   64'(pprot_o),   64'(pr));
    check("setup.pwdata",  64'(pwdata_o),  64'(wd));
    check("setup.pstrb",   64'(pstrb_o),   64'(wr ? st : 4'h0));
  endtask

  // Wait (bounded) for a response, compare against the scoreboard, consume it.
  task automatic take_rsp(input string tag);
    exp_t e;
    int   n = 0;
    while (rsp_valid_o !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check({tag, ".rsp_valid"}, 64'(rsp_valid_o), 64'(1));
    check({tag, ".psel_off"},  64'(psel_o),      64'(0));
    if (exp_q.size() == 0) begin
      check({tag, ".sb_nonempty"}, 64'(exp_q.size()), 64'(1));
    end else begin
      e = exp_q.pop_front();
      check({tag, ".rdata"}, 64'(rsp_rdata_o), 64'(e.rdata));
      check({tag, ".err"},   64'(rsp_err_o),   64'(e.err));
      check({tag, ".tout"},  64'(rsp_tout_o),  64'(e.tout));
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    check({tag, ".rsp_clr"},   64'(rsp_valid_o), 64'(0));
    check({tag, ".req_ready"}, 64'(req_ready_o), 64'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset ----
    #1 rst_i = 1'b1;
    #2;
    check("rst.psel",      64'(psel_o),      64'(0));
    check("rst.penable",   64'(penable_o),   64'(0));
    check("rst.rsp_valid", 64'(rsp_valid_o), 64'(0));
    check("rst.paddr",     64'(paddr_o),     64'(0));
    check("rst.rsp_err",   64'(rsp_err_o),   64'(0));
    #9 rst_i = 1'b0;
    step();
    check("rst.req_ready", 64'(req_ready_o), 64'(1));

    // ---- 1: write, no wait states ----
    pready_i = 1'b1;
    send(32'h0000_0004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b010, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    check("wr.penable", 64'(penable_o), 64'(1));
    check("wr.psel",    64'(psel_o),    64'(1));
    check("wr.pwdata",  64'(pwdata_o),  64'(32'hDEAD_BEEF));
    step();
    check("wr.rsp_at_n3", 64'(rsp_valid_o), 64'(1));
    check("wr.penable_off", 64'(penable_o), 64'(0));
    take_rsp("wr");

    // ---- 2: read with 3 wait states, pslverr ignored while waiting ----
    pready_i  = 1'b0;
    pslverr_i = 1'b1;
    send(32'h0000_0008, 1'b0, 32'h1111_2222, 4'hF, 3'b000, 32'h5, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rd_ws.penable", 64'(penable_o),   64'(1));
      check("rd_ws.no_rsp",  64'(rsp_valid_o), 64'(0));
      check("rd_ws.pstrb",   64'(pstrb_o),     64'(0));
    end
    step();
    check("rd_ws.penable4", 64'(penable_o), 64'(1));
    pready_i  = 1'b1;
    pslverr_i = 1'b0;
    prdata_i  = 32'h0000_0005;
    step();
    check("rd_ws.rsp_at_n6", 64'(rsp_valid_o), 64'(1));
    prdata_i  = 32'hFFFF_FFFF;
    take_rsp("rd_ws");

    // ---- 3: read completed with pslverr ----
    pready_i  = 1'b1;
    pslverr_i = 1'b1;
    prdata_i  = 32'hA5A5_0001;
    send(32'h0000_000C, 1'b0, 32'h0, 4'h0, 3'b001, 32'hA5A5_0001, 1'b1, 1'b0, 1'b1);
    step();
    step();
    pslverr_i = 1'b0;
    prdata_i  = 32'h0;
    take_rsp("rd_err");

    // ---- 4: back-to-back requests, response stalled 5 cycles ----
    pready_i = 1'b1;
    send(32'h0000_0010, 1'b1, 32'h1234_5678, 4'h3, 3'b100, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    step();
    req_valid_i = 1'b1;
    req_addr_i  = 32'h0000_0020;
    req_write_i = 1'b0;
    req_strb_i  = 4'hF;
    req_prot_i  = 3'b000;
    prdata_i    = 32'hCAFE_0001;
    exp_q.push_back('{rdata: 32'hCAFE_0001, err: 1'b0, tout: 1'b0});
    for (int i = 0; i < 5; i++) begin
      check("b2b.req_ready0", 64'(req_ready_o), 64'(0));
      check("b2b.psel0",      64'(psel_o),      64'(0));
      check("b2b.rsp_hold",   64'(rsp_valid_o), 64'(1));
      check("b2b.rdata_hold", 64'(rsp_rdata_o), 64'(0));
      check("b2b.paddr_hold", 64'(paddr_o),     64'(32'h10));
      step();
    end
    take_rsp("b2b_a");
    check("b2b.no_setup_yet", 64'(psel_o), 64'(0));
    step();
    req_valid_i = 1'b0;
    check("b2b.second_psel",  64'(psel_o),  64'(1));
    check("b2b.second_paddr", 64'(paddr_o), 64'(32'h20));
    check("b2b.second_pstrb", 64'(pstrb_o), 64'(0));
    step();
    step();
    take_rsp("b2b_b");

`ifdef APB4_MST_BRIDGE_TIMEOUT_EN
    // ---- 5: timeout with pready stuck low ----
    pready_i = 1'b0;
    prdata_i = 32'h5555_AAAA;
    send(32'h0000_0030, 1'b0, 32'h0, 4'h0, 3'b000, 32'h0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("tout.penable", 64'(penable_o), 64'(1));
    end
    step();
    check("tout.psel_off",    64'(psel_o),      64'(0));
    check("tout.penable_off", 64'(penable_o),   64'(0));
    check("tout.rsp",         64'(rsp_valid_o), 64'(1));
    take_rsp("tout");

    // ---- 5b: pready arrives on the last permitted cycle ----
    send(32'h0000_0034, 1'b0, 32'h0, 4'h0, 3'b000, 32'h77, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step();
    pready_i = 1'b1;
    prdata_i = 32'h77;
    step();
    check("tout_edge.rsp", 64'(rsp_valid_o), 64'(1));
    take_rsp("tout_edge");
`endif

    // ---- 6: asynchronous reset during ACCESS ----
    pready_i = 1'b0;
    send(32'h0000_0040, 1'b0, 32'h0, 4'h0, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    check("arst.in_access", 64'(penable_o), 64'(1));
    #2 rst_i = 1'b1;
    #1;
    check("arst.psel",      64'(psel_o),      64'(0));
    check("arst.penable",   64'(penable_o),   64'(0));
    check("arst.rsp_valid", 64'(rsp_valid_o), 64'(0));
    #1 rst_i = 1'b0;
    pready_i = 1'b1;
    step();
    check("arst.req_ready", 64'(req_ready_o), 64'(1));
    for (int i = 0; i < 3; i++) begin
      check("arst.no_rsp",  64'(rsp_valid_o), 64'(0));
      check("arst.no_psel", 64'(psel_o),      64'(0));
      step();
    end

    // ---- 7: normal write after the aborted transfer ----
    send(32'h0000_0044, 1'b1, 32'h0BAD_F00D, 4'h5, 3'b011, 32'h0, 1'b0, 1'b0, 1'b1);
    step();
    step();
    take_rsp("post_rst");

    check("sb.drained", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
